// File: rtl/multi_channel_alu.sv
// Multi-channel add/sub/multiply/divide unit with a valid/ready handshake.
// Multiply and divide iterate one bit per clock; all channels run in lockstep.
module multi_channel_alu #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [CHANNELS*WIDTH-1:0]      i_a,
  input  logic [CHANNELS*WIDTH-1:0]      i_b,
  input  logic [1:0]                     i_mode,
  input  logic                           i_main_mode,
  output logic [CHANNELS*2*WIDTH-1:0]    o_r,
  output logic                           o_valid,
  output logic [CHANNELS-1:0]            o_div0
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t                        state_q, state_d;
  logic   [CW-1:0]               cnt_q;
  logic   [CHANNELS*WIDTH-1:0]   a_q, b_q;
  op_t                           mode_q;
  logic                          sgn_q;
  logic                          accept, calc_en, last;
  logic   [CHANNELS*2*WIDTH-1:0] r_d;
  logic   [CHANNELS-1:0]         div0_d;

  assign o_ready = (state_q == IDLE) && !i_rst;
  assign o_valid = (state_q == DONE);
  assign accept  = i_valid && o_ready;
  assign calc_en = (state_q == CALC);
  // Add/sub finish in a single CALC cycle; the iterative ops need WIDTH.
  assign last    = (mode_q == OP_ADD) || (mode_q == OP_SUB) || (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (last)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= OP_ADD;
      sgn_q   <= 1'b0;
      o_r     <= '0;
      o_div0  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= i_a;
        b_q    <= i_b;
        mode_q <= op_t'(i_mode);
        sgn_q  <= i_main_mode;
        cnt_q  <= '0;
      end else if (calc_en) begin
        cnt_q <= cnt_q + CW'(1);
        if (last) begin
          o_r    <= r_d;
          o_div0 <= div0_d;
        end
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0]   a_k, b_k, a_in, a_in_mag, b_mag;
    logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d, quot, rem;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     sum, shifted, diff, ext_a, ext_b, addsub;
    logic [2*WIDTH-1:0] prod, res;
    logic               div0;

    assign a_k      = a_q[k*WIDTH +: WIDTH];
    assign b_k      = b_q[k*WIDTH +: WIDTH];
    assign a_neg    = sgn_q && a_k[WIDTH-1];
    assign b_neg    = sgn_q && b_k[WIDTH-1];
    assign b_mag    = b_neg ? -b_k : b_k;
    assign a_in     = i_a[k*WIDTH +: WIDTH];
    assign a_in_mag = (i_main_mode && a_in[WIDTH-1]) ? -a_in : a_in;

    // hi/lo hold {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag} : '0);
      shifted = {hi_q, lo_q[WIDTH-1]};
      diff    = shifted - {1'b0, b_mag};
      hi_d    = sum[WIDTH:1];
      lo_d    = {sum[0], lo_q[WIDTH-1:1]};
      if (mode_q == OP_DIV) begin
        if (shifted >= {1'b0, b_mag}) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end

      prod = {hi_d, lo_d};
      if (a_neg ^ b_neg) prod = -prod;
      quot = (a_neg ^ b_neg) ? -lo_d : lo_d;
      rem  = a_neg ? -hi_d : hi_d;

      ext_a  = {a_neg, a_k};
      ext_b  = {b_neg, b_k};
      addsub = (mode_q == OP_SUB) ? ext_a - ext_b : ext_a + ext_b;

      div0 = 1'b0;
      case (mode_q)
        OP_MUL:  res = prod;
        OP_DIV: begin
          if (b_k == '0) begin
            res  = {a_k, {WIDTH{1'b1}}};
            div0 = 1'b1;
          end else begin
            res = {rem, quot};
          end
        end
        default: res = {{(WIDTH-1){sgn_q && addsub[WIDTH]}}, addsub};
      endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        // NOTE: datapath registers are reset too, so an aborted operation leaves no partial state.
        hi_q <= '0;
        lo_q <= '0;
      end else if (accept) begin
        hi_q <= '0;
        lo_q <= a_in_mag;
      end else if (calc_en) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end

    assign r_d[k*2*WIDTH +: 2*WIDTH] = res;
    assign div0_d[k]                 = div0;
  end

endmodule
